regfile_nrmw: RTL
=================

# regfile_nrmw

Parametrised multi-ported register file with a per-entry ready (scoreboard) bit, the next generation of the fixed 4-read/4-write array in the operand-read stage. It supports NUM_RD read ports, NUM_WR writeback ports and NUM_ALLOC allocate ports (which clear ready), with registered read outputs, optional write-to-read bypass and a live count of not-ready entries for rename-stage backpressure.

## Interface
- DATA_WIDTH, 16, operand width
- ENTRIES, 32, number of registers (power of two, ≥ 2)
- ADDR_WIDTH, $clog2(ENTRIES), register index width
- NUM_RD, 4, read ports
- NUM_WR, 2, writeback ports (data write + set ready)
- NUM_ALLOC, 2, allocate ports (clear ready, data untouched)
- BYPASS, 1, 1 = same-cycle write forwarded to read; 0 = read sees pre-write state
- ZERO_REG, 1, 1 = entry 0 reads 0, always ready, ignores writes/allocs

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en_i  in  NUM_WR  writeback enable per port
- wr_addr_i  in  NUM_WR×ADDR_WIDTH  writeback index
- wr_data_i  in  NUM_WR×DATA_WIDTH  writeback data
- alloc_en_i  in  NUM_ALLOC  allocate enable per port
- alloc_addr_i  in  NUM_ALLOC×ADDR_WIDTH  entry to mark not-ready
- rd_en_i  in  NUM_RD  read request per port
- rd_addr_i  in  NUM_RD×ADDR_WIDTH  read index
- rd_data_o  out  NUM_RD×DATA_WIDTH  registered read data
- rd_ready_o  out  NUM_RD  registered ready bit of the read entry
- rd_valid_o  out  NUM_RD  rd_en_i delayed one cycle
- busy_count_o  out  ADDR_WIDTH+1  number of entries with ready = 0

## Operation
- State per entry: data[DATA_WIDTH], ready[1]. Reset (rst=0, async): all data 0, all ready 1, busy count 0.
- Writeback: wr_en_i[p] writes wr_data_i[p] to wr_addr_i[p] and sets its ready bit. Multiple ports to one entry in one cycle: lowest-numbered port's data wins; ready set once.
- Allocate: alloc_en_i[a] clears ready of alloc_addr_i[a]; data unchanged. Duplicate alloc addresses count once.
- Alloc and writeback on same entry same cycle: data written, ready ends 0 (alloc wins).
- Read: on rd_en_i[r], next cycle rd_data_o[r] = entry data, rd_ready_o[r] = entry ready, rd_valid_o[r] = 1. Without rd_en_i, rd_data_o/rd_ready_o hold previous value, rd_valid_o = 0.
- BYPASS=1: read sampling the same index as an enabled write this cycle returns the post-edge data and ready (write-first, including alloc-wins rule). BYPASS=0: returns pre-edge values.
- ZERO_REG=1: entry 0 reads data 0, ready 1; writes and allocs to entry 0 ignored and never counted busy.
- busy_count_o: registered; next = current + (distinct entries going ready→0) − (distinct entries going 0→1). Range 0..ENTRIES, never wraps.

## Timing
- Read latency 1 cycle, fully pipelined; every port accepts a request every cycle; no stalls.
- Write/alloc take effect at the edge; visible to a read issued the following cycle (same cycle only with BYPASS=1).
- busy_count_o reflects the edge's updates in the same cycle the ready bits change.
- Reset outputs: rd_data_o 0, rd_ready_o 0, rd_valid_o 0, busy_count_o 0. Reset mid-operation drops in-flight reads (rd_valid_o 0 the cycle after release unless a new request is made).
- No combinational path input→output.

## Structure
- Package regfile_pkg: typedefs for index and data (parametrised via localparam defaults), priority-select function for lowest-index write, popcount function.
- Sub-module regfile_entry: one entry's data/ready flops with per-entry write-enable vector, alloc hit, priority data mux; generated ENTRIES times. Read muxes and busy counter in top.

## Test plan
- Reset then read all 32 entries on 4 ports -> rd_data_o 0, rd_ready_o 1, busy_count_o 0.
- Alloc entry 5, next cycle read 5 -> rd_ready_o 0, busy_count_o 1; writeback 0xBEEF to 5, read -> 0xBEEF, ready 1, count 0.
- wr port0 0x1111 and port1 0x2222 both to entry 7 -> entry 7 = 0x1111, ready 1.
- Alloc and writeback 0x3333 to entry 9 same cycle -> data 0x3333, ready 0, count +1; duplicate alloc of entry 9 on both ports -> count +1 only.
- BYPASS=1: write 0xAAAA to 3 and read 3 same cycle -> next cycle 0xAAAA; BYPASS=0 -> old value.
- ZERO_REG=1: write 0xFFFF and alloc entry 0 -> read returns 0, ready 1, count unchanged; assert rst mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the ready-tracking register file.
// Vector helpers work on a fixed wide vector; callers zero-extend into vec_t.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ENTRIES    = 32;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_ENTRIES);

  // Upper bound on ENTRIES and on port counts handled by the helpers below.
  localparam int MAX_VEC = 256;
  localparam int CNT_W   = $clog2(MAX_VEC) + 1;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] idx_t;
  typedef logic [MAX_VEC-1:0]        vec_t;
  typedef logic [CNT_W-1:0]          cnt_t;

  // Isolates the lowest set bit, so the lowest-numbered write port wins.
  function automatic vec_t lowest_onehot(input vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  function automatic cnt_t popcount(input vec_t v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_VEC; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register file entry: data and ready flops plus write-priority mux.
// Also exposes the post-edge values for write-first bypass and busy tracking.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WR     = 2,
  parameter bit IS_ZERO    = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WR-1:0]                wr_hit_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic                             alloc_hit_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             ready_o,
  output logic [DATA_WIDTH-1:0]            data_nxt_o,
  output logic                             ready_nxt_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic [NUM_WR-1:0]     wr_sel;

  always_comb begin
    wr_sel  = NUM_WR'(lowest_onehot(vec_t'(wr_hit_i)));
    data_d  = data_q;
    ready_d = ready_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_sel[p]) data_d = wr_data_i[p];
    end
    if (|wr_hit_i) ready_d = 1'b1;
    // Allocation beats a same-cycle writeback on the ready bit.
    if (alloc_hit_i) ready_d = 1'b0;
    if (IS_ZERO) begin
      data_d  = '0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign data_o      = data_q;
  assign ready_o     = ready_q;
  assign data_nxt_o  = data_d;
  assign ready_nxt_o = ready_d;

endmodule

// File: rtl/regfile_nrmw.sv
// Multi-ported register file with per-entry ready bit, registered reads,
// optional write-to-read bypass and a running count of not-ready entries.
module regfile_nrmw
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ENTRIES    = DEF_ENTRIES,
  parameter int ADDR_WIDTH = $clog2(ENTRIES),
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int NUM_ALLOC  = 2,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WR-1:0]                    wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data_i,
  input  logic [NUM_ALLOC-1:0]                 alloc_en_i,
  input  logic [NUM_ALLOC-1:0][ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic [NUM_RD-1:0]                    rd_en_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]                    rd_ready_o,
  output logic [NUM_RD-1:0]                    rd_valid_o,
  output logic [ADDR_WIDTH:0]                  busy_count_o
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ENTRIES-1:0][NUM_WR-1:0]     wr_hit;
  logic [ENTRIES-1:0]                 alloc_hit;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] ent_data, ent_data_nxt;
  logic [ENTRIES-1:0]                 ent_ready, ent_ready_nxt;
  logic [ENTRIES-1:0]                 went_busy, went_free;

  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]                 rd_ready_q, rd_ready_d;
  logic [NUM_RD-1:0]                 rd_valid_q, rd_valid_d;
  logic [CW-1:0]                     busy_q, busy_d;

  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      alloc_hit[e] = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        wr_hit[e][p] = wr_en_i[p] && (wr_addr_i[p] == ADDR_WIDTH'(e));
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (alloc_en_i[a] && (alloc_addr_i[a] == ADDR_WIDTH'(e))) alloc_hit[e] = 1'b1;
      end
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    regfile_entry #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR),
      .IS_ZERO    (ZERO_REG && (e == 0))
    ) u_entry (
      .clk         (clk),
      .rst         (rst),
      .wr_hit_i    (wr_hit[e]),
      .wr_data_i   (wr_data_i),
      .alloc_hit_i (alloc_hit[e]),
      .data_o      (ent_data[e]),
      .ready_o     (ent_ready[e]),
      .data_nxt_o  (ent_data_nxt[e]),
      .ready_nxt_o (ent_ready_nxt[e])
    );
  end

  // Read handshake: rd_en_i is accepted every cycle with no backpressure;
  // rd_valid_o pulses exactly one cycle later with that request's data/ready,
  // and data/ready hold their last value while rd_valid_o is low.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_ready_d = rd_ready_q;
    rd_valid_d = rd_en_i;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_en_i[r]) begin
        if (BYPASS) begin
          rd_data_d[r]  = ent_data_nxt[rd_addr_i[r]];
          rd_ready_d[r] = ent_ready_nxt[rd_addr_i[r]];
        end else begin
          rd_data_d[r]  = ent_data[rd_addr_i[r]];
          rd_ready_d[r] = ent_ready[rd_addr_i[r]];
        end
      end
    end
  end

  // Per-entry transitions make duplicate allocs/writes count only once.
  always_comb begin
    went_busy = ent_ready & ~ent_ready_nxt;
    went_free = ~ent_ready & ent_ready_nxt;
    busy_d    = busy_q + CW'(popcount(vec_t'(went_busy))) - CW'(popcount(vec_t'(went_free)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_ready_q <= '0;
      rd_valid_q <= '0;
      busy_q     <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_ready_o   = rd_ready_q;
  assign rd_valid_o   = rd_valid_q;
  assign busy_count_o = busy_q;

endmodule
